// File: rtl/ccg_lut_pkg.sv
// ccg_lut_pkg: shared types and helpers for the LUT evaluator.
// Optional feature macro used by the top: CCG_LUT_PARITY_EN.
package ccg_lut_pkg;

  localparam int N_IN_MAX  = 6;
  localparam int N_OUT_MAX = 32;

  typedef enum logic {UNCFG, RUN} ccg_lut_state_e;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/ccg_lut_cell.sv
// ccg_lut_cell: one programmable truth table with written flag.
// Lookup is purely combinational on the stored table.
module ccg_lut_cell
  import ccg_lut_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [tt_width(N_IN)-1:0] i_tt,
  input  logic [N_IN-1:0]           i_x,
  output logic                      o_val,
  output logic                      o_written
);

  localparam int TT_W = tt_width(N_IN);

  logic [TT_W-1:0] r_tt;
  logic            r_written;

  // Table store and sticky written flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tt      <= '0;
      r_written <= 1'b0;
    end else if (i_we) begin
      r_tt      <= i_tt;
      r_written <= 1'b1;
    end
  end

  assign o_val     = r_tt[i_x];
  assign o_written = r_written;

endmodule

// File: rtl/ccg_lut_eval.sv
// ccg_lut_eval: registered multi-output truth-table evaluator.
// Define CCG_LUT_PARITY_EN to add the f_par output (^f).
module ccg_lut_eval
  import ccg_lut_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 10,
  localparam int TT_W  = tt_width(N_IN),
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [TT_W-1:0]  cfg_tt,
  output logic             cfg_err,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f
`ifdef CCG_LUT_PARITY_EN
 ,output logic             f_par
`endif
);

  ccg_lut_state_e r_state;
  ccg_lut_state_e w_state_nxt;

  logic [N_OUT-1:0] w_lut;
  logic [N_OUT-1:0] w_mask;
  logic             w_sel_ok;
  logic             w_accept;
  logic             w_in_ready;
  logic             r_cfg_err;
  logic             r_cfg_done;
  logic             r_out_valid;
  logic [N_OUT-1:0] r_f;

  assign w_sel_ok = 32'(cfg_sel) < N_OUT;

  for (genvar k = 0; k < N_OUT; k++) begin : g_cell
    ccg_lut_cell #(
      .N_IN(N_IN)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (cfg_we && (32'(cfg_sel) == k)),
      .i_tt     (cfg_tt),
      .i_x      (x),
      .o_val    (w_lut[k]),
      .o_written(w_mask[k])
    );
  end

  // Config status: one-cycle error pulse and sticky done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err  <= 1'b0;
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_err  <= cfg_we && !w_sel_ok;
      r_cfg_done <= r_cfg_done | (&w_mask);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= UNCFG;
    else        r_state <= w_state_nxt;
  end

  // Next state and input-side ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    unique case (r_state)
      UNCFG: begin
        if (&w_mask) w_state_nxt = RUN;
      end
      RUN: begin
        w_in_ready = !r_out_valid || out_ready;
      end
      default: w_state_nxt = UNCFG;
    endcase
  end

  assign w_accept = in_valid && w_in_ready;

  // Output stage: load on accept, clear valid on drain only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_f         <= w_lut;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CCG_LUT_PARITY_EN
  logic r_f_par;

  // Parity registered alongside f with identical hold rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_f_par <= 1'b0;
    else if (w_accept) r_f_par <= ^w_lut;
  end

  assign f_par = r_f_par;
`endif

  assign cfg_err   = r_cfg_err;
  assign cfg_done  = r_cfg_done;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign f         = r_f;

endmodule

// File: tb/tb_ccg_lut_eval.sv
// tb_ccg_lut_eval: scoreboard bench for ccg_lut_eval (N_IN=3, N_OUT=5).
// Honours CCG_LUT_PARITY_EN when defined.
module tb_ccg_lut_eval;

  localparam int NI = 3;
  localparam int NO = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_sel = '0;
  logic [7:0]    cfg_tt = '0;
  logic          cfg_err;
  logic          cfg_done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NI-1:0] x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NO-1:0] f;
`ifdef CCG_LUT_PARITY_EN
  logic          f_par;
`endif

  ccg_lut_eval #(
    .N_IN (NI),
    .N_OUT(NO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_tt   (cfg_tt),
    .cfg_err  (cfg_err),
    .cfg_done (cfg_done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f)
`ifdef CCG_LUT_PARITY_EN
   ,.f_par    (f_par)
`endif
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    m_tt [NO];
  logic [NO-1:0] q [$];

  function automatic logic [NO-1:0] model(input logic [NI-1:0] xi);
    logic [NO-1:0] r;
    logic [7:0]    t;
    for (int k = 0; k < NO; k++) begin
      t    = m_tt[k];
      r[k] = t[xi];
    end
    return r;
  endfunction

  // Sample just before the edge, update scoreboard, advance one cycle.
  task automatic step();
    logic [NO-1:0] e;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL drain_empty f=%b with no expected result", f);
      end else begin
        e = q.pop_front();
        if (f !== e) begin
          errors++;
          $display("FAIL result f=%b expected %b", f, e);
        end
      end
`ifdef CCG_LUT_PARITY_EN
      checks++;
      if (f_par !== ^f) begin
        errors++;
        $display("FAIL parity f_par=%b expected %b", f_par, ^f);
      end
`endif
    end
    if (in_valid && in_ready) q.push_back(model(x));
    if (cfg_we && cfg_sel < 3'(NO)) m_tt[cfg_sel] = cfg_tt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] s, input logic [7:0] t);
    cfg_we  = 1'b1;
    cfg_sel = s;
    cfg_tt  = t;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (q.size() == 0) break;
      step();
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain left=%0d out_valid=%b expected 0/0",
               q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NO; k++) m_tt[k] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || cfg_done !== 1'b0 ||
        cfg_err !== 1'b0 || f !== '0) begin
      errors++;
      $display("FAIL reset ov=%b rdy=%b done=%b err=%b f=%b expected all 0",
               out_valid, in_ready, cfg_done, cfg_err, f);
    end
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    x         = 3'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || cfg_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_uncfg rdy=%b ov=%b done=%b expected 0/0/0",
                 in_ready, out_valid, cfg_done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_config();
    wr(3'd0, 8'h88);
    wr(3'd1, 8'h66);
    wr(3'd2, 8'hFE);
    wr(3'd3, 8'h01);
    checks++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL early_done cfg_done=%b expected 0", cfg_done);
    end
    wr(3'd4, 8'h96);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (cfg_done === 1'b1 && in_ready === 1'b1) break;
      step();
    end
    checks++;
    if (cfg_done !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_done_timeout done=%b rdy=%b expected 1/1",
               cfg_done, in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 3'd3;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || f !== 5'b00101) begin
      errors++;
      $display("FAIL basic_x3 ov=%b f=%b expected 1/00101", out_valid, f);
    end
    step();
    in_valid = 1'b1;
    x        = 3'd1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || f !== 5'b10110) begin
      errors++;
      $display("FAIL basic_x1 ov=%b f=%b expected 1/10110", out_valid, f);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [NO-1:0] e;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 3'd5;
    e         = model(3'd5);
    step();
    x = 3'd6;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || f !== e || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold ov=%b f=%b rdy=%b expected 1/%b/0",
                 out_valid, f, in_ready, e);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL burst_valid beat=%0d ov=%b expected 1", i, out_valid);
      end
    end
    drain();
  endtask

  task automatic test_cfg_err();
    out_ready = 1'b1;
    wr(3'd5, 8'hFF);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_pulse cfg_err=%b expected 1", cfg_err);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear cfg_err=%b expected 0", cfg_err);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      step();
    end
    drain();
  endtask

  task automatic test_same_cycle();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 3'd3;
    cfg_we    = 1'b1;
    cfg_sel   = 3'd0;
    cfg_tt    = 8'h00;
    step();
    cfg_we = 1'b0;
    checks++;
    if (f[0] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_old f0=%b expected 1", f[0]);
    end
    step();
    checks++;
    if (f[0] !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_new f0=%b expected 0", f[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 3'd7;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pending ov=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || f !== '0 || cfg_done !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ov=%b f=%b done=%b rdy=%b expected 0",
               out_valid, f, cfg_done, in_ready);
    end
`ifdef CCG_LUT_PARITY_EN
    checks++;
    if (f_par !== 1'b0) begin
      errors++;
      $display("FAIL reset_par f_par=%b expected 0", f_par);
    end
`endif
    q.delete();
    for (int k = 0; k < NO; k++) m_tt[k] = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_uncfg rdy=%b ov=%b expected 0/0",
                 in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config();
    test_basic();
    test_backpressure();
    test_cfg_err();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
